ysyx_23060203_bpu: RTL and testbench

//  Fetch-side branch predictor; the counterpart of the branch resolver in IDU.
//  - Fetch asks: taken, and to where?  IDU later reports the resolved outcome
//    (jump_en, target) back through the update port.
//  - Direct-mapped BTB with one 2-bit saturating counter per entry.
//  - Lookup result is registered (1-cycle latency) and feeds the IFU next-PC mux.

---
 rtl/ysyx_23060203_bpu.sv | 108 ++++++++++
 tb/tb_ysyx_23060203_bpu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_bpu.sv
// rtl/ysyx_23060203_bpu.sv - direct-mapped BTB branch predictor with 2-bit counters
// Optional event counters: define YSYX_23060203_BPU_PERF_EN.
module ysyx_23060203_bpu #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    input  logic        flush,
    output logic        resp_valid,
    output logic        resp_taken,
    output logic [31:0] resp_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
`ifdef YSYX_23060203_BPU_PERF_EN
    ,
    output logic [31:0] perf_lookup,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_upd
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic             tbl_valid  [ENTRIES];
    logic [TAG_W-1:0] tbl_tag    [ENTRIES];
    logic [31:0]      tbl_target [ENTRIES];
    logic [1:0]       tbl_ctr    [ENTRIES];

    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] req_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             req_fire;
    logic             req_hit;
    logic             upd_hit;
    logic             pred_taken;
    logic             unused_pc;

    // Only the index/tag window of each PC matters; the rest is intentionally dropped.
    assign unused_pc  = ^{req_pc, upd_pc};

    assign req_idx    = req_pc[IDX_W+1:2];
    assign req_tag    = req_pc[IDX_W+2 +: TAG_W];
    assign upd_idx    = upd_pc[IDX_W+1:2];
    assign upd_tag    = upd_pc[IDX_W+2 +: TAG_W];
    assign req_fire   = req_valid & ~flush;
    assign req_hit    = tbl_valid[req_idx] && (tbl_tag[req_idx] == req_tag);
    assign upd_hit    = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);
    assign pred_taken = req_fire & req_hit & tbl_ctr[req_idx][1];

    // Table write; lookups in the same cycle see the old contents through the response register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= '0;
                tbl_ctr[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    tbl_ctr[upd_idx]    <= (tbl_ctr[upd_idx] == 2'b11) ? 2'b11 : tbl_ctr[upd_idx] + 2'd1;
                    tbl_target[upd_idx] <= upd_target;
                end else begin
                    tbl_ctr[upd_idx]    <= (tbl_ctr[upd_idx] == 2'b00) ? 2'b00 : tbl_ctr[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                tbl_valid[upd_idx]  <= 1'b1;
                tbl_tag[upd_idx]    <= upd_tag;
                tbl_target[upd_idx] <= upd_target;
                tbl_ctr[upd_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid  <= 1'b0;
            resp_taken  <= 1'b0;
            resp_target <= '0;
        end else begin
            resp_valid  <= req_fire;
            resp_taken  <= pred_taken;
            resp_target <= pred_taken ? tbl_target[req_idx] : 32'd0;
        end
    end

`ifdef YSYX_23060203_BPU_PERF_EN
    // Hits are counted on the edge that launches the matching response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_lookup <= '0;
            perf_hit    <= '0;
            perf_upd    <= '0;
        end else begin
            if (req_fire)           perf_lookup <= perf_lookup + 32'd1;
            if (req_fire & req_hit) perf_hit    <= perf_hit + 32'd1;
            if (upd_valid)          perf_upd    <= perf_upd + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060203_bpu.sv
// tb/tb_ysyx_23060203_bpu.sv - directed self-checking bench for ysyx_23060203_bpu
// Perf counter checks enabled with YSYX_23060203_BPU_PERF_EN.
module tb_ysyx_23060203_bpu;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_taken;
    logic [31:0] resp_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
`ifdef YSYX_23060203_BPU_PERF_EN
    logic [31:0] perf_lookup;
    logic [31:0] perf_hit;
    logic [31:0] perf_upd;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060203_bpu dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_pc      (req_pc),
        .flush       (flush),
        .resp_valid  (resp_valid),
        .resp_taken  (resp_taken),
        .resp_target (resp_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
`ifdef YSYX_23060203_BPU_PERF_EN
        ,
        .perf_lookup (perf_lookup),
        .perf_hit    (perf_hit),
        .perf_upd    (perf_upd)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        tick();
        upd_valid  = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic v, input logic t, input logic [31:0] tgt);
        check({tag, ".valid"},  {31'd0, resp_valid}, {31'd0, v});
        check({tag, ".taken"},  {31'd0, resp_taken}, {31'd0, t});
        check({tag, ".target"}, resp_target, tgt);
    endtask

    initial begin
        #12;
        expect_resp("reset", 1'b0, 1'b0, 32'h0);
        reset_n = 1'b1;
        tick();

        // cold lookup misses, then idle cycle drops resp_valid
        lookup(32'h8000_0000);
        expect_resp("cold", 1'b1, 1'b0, 32'h0);
        tick();
        expect_resp("idle", 1'b0, 1'b0, 32'h0);

        // allocate weakly taken
        update(32'h8000_0010, 1'b1, 32'h8000_0100);
        lookup(32'h8000_0010);
        expect_resp("alloc", 1'b1, 1'b1, 32'h8000_0100);

        // 10 -> 11 -> 11(sat) -> 11, target retrained on a hit
        update(32'h8000_0010, 1'b1, 32'h8000_0100);
        update(32'h8000_0010, 1'b1, 32'h8000_0200);
        update(32'h8000_0010, 1'b1, 32'h8000_0200);
        update(32'h8000_0010, 1'b0, 32'h8000_0dea);
        lookup(32'h8000_0010);
        expect_resp("ctr10", 1'b1, 1'b1, 32'h8000_0200);
        update(32'h8000_0010, 1'b0, 32'h0);
        lookup(32'h8000_0010);
        expect_resp("ctr01", 1'b1, 1'b0, 32'h0);
        update(32'h8000_0010, 1'b0, 32'h0);
        update(32'h8000_0010, 1'b0, 32'h0);
        update(32'h8000_0010, 1'b1, 32'h8000_0300);
        lookup(32'h8000_0010);
        expect_resp("sat00", 1'b1, 1'b0, 32'h0);
        update(32'h8000_0010, 1'b1, 32'h8000_0300);
        lookup(32'h8000_0010);
        expect_resp("ctr10b", 1'b1, 1'b1, 32'h8000_0300);

        // aliasing: same index, different tag replaces the entry
        update(32'h8000_0050, 1'b1, 32'h8000_0500);
        lookup(32'h8000_0010);
        expect_resp("alias_old", 1'b1, 1'b0, 32'h0);
        lookup(32'h8000_0050);
        expect_resp("alias_new", 1'b1, 1'b1, 32'h8000_0500);

        // miss + not taken does not allocate
        update(32'h8000_0020, 1'b0, 32'h8000_0777);
        update(32'h8000_0020, 1'b1, 32'h8000_0777);
        lookup(32'h8000_0020);
        expect_resp("no_alloc", 1'b1, 1'b1, 32'h8000_0777);

        // same-cycle lookup and update: read-before-write
        req_valid = 1'b1; req_pc = 32'h8000_0080;
        upd_valid = 1'b1; upd_pc = 32'h8000_0080; upd_taken = 1'b1; upd_target = 32'h8000_0800;
        tick();
        req_valid = 1'b0; upd_valid = 1'b0;
        expect_resp("rbw", 1'b1, 1'b0, 32'h0);
        lookup(32'h8000_0080);
        expect_resp("rbw_after", 1'b1, 1'b1, 32'h8000_0800);

        // flush kills the lookup but not a concurrent update
        req_valid = 1'b1; req_pc = 32'h8000_0050; flush = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h8000_0090; upd_taken = 1'b1; upd_target = 32'h8000_0900;
        tick();
        req_valid = 1'b0; upd_valid = 1'b0; flush = 1'b0;
        expect_resp("flush", 1'b0, 1'b0, 32'h0);
        lookup(32'h8000_0090);
        expect_resp("flush_upd", 1'b1, 1'b1, 32'h8000_0900);

        // async reset mid-stream
        #2;
        reset_n = 1'b0;
        #1;
        expect_resp("async_rst", 1'b0, 1'b0, 32'h0);
`ifdef YSYX_23060203_BPU_PERF_EN
        check("perf_lookup_rst", perf_lookup, 32'd0);
        check("perf_hit_rst",    perf_hit,    32'd0);
        check("perf_upd_rst",    perf_upd,    32'd0);
`endif
        #10;
        reset_n = 1'b1;
        tick();
        lookup(32'h8000_0090);
        expect_resp("post_rst", 1'b1, 1'b0, 32'h0);
        update(32'h8000_0090, 1'b1, 32'h8000_0a00);
        lookup(32'h8000_0090);
        expect_resp("post_rst_learn", 1'b1, 1'b1, 32'h8000_0a00);
        req_valid = 1'b1; req_pc = 32'h8000_0090; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
`ifdef YSYX_23060203_BPU_PERF_EN
        check("perf_lookup", perf_lookup, 32'd2);
        check("perf_hit",    perf_hit,    32'd1);
        check("perf_upd",    perf_upd,    32'd1);
`endif
        check("final_flush_valid", {31'd0, resp_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
